// File: rtl/tdm_deser_ctrl.sv
// TDM serial front-end sequencer: bit ticks, frame sync, deserializer strobes.
// Optional SYNC_ERR_CNT_EN adds a saturating 8-bit sync-error counter.
module tdm_deser_ctrl #(
  parameter int WORD_LEN = 24,
  parameter int NUM_CH   = 2,
  parameter int CH_W     = 1,
  parameter int BCLK_DIV = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_fsync,
  input  logic            i_sdata,
  output logic            o_des_en,
  output logic            o_des_din,
  output logic            o_des_din_valid,
  output logic [CH_W-1:0] ov_ch,
  output logic            o_busy,
  output logic            o_sync_err
`ifdef SYNC_ERR_CNT_EN
  ,
  output logic [7:0]      ov_err_cnt
`endif
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [DW-1:0]   DIV_MAX = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0]   BIT_MAX = BW'(WORD_LEN - 1);
  localparam logic [CH_W-1:0] CH_MAX  = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    RUN
  } state_t;

  state_t          state, state_d;
  logic [DW-1:0]   div_cnt, div_d;
  logic [BW-1:0]   bit_cnt, bit_d;
  logic [CH_W-1:0] ch, ch_d;
  logic            en_d, din_d, vld_d, err_d;
  logic [CH_W-1:0] och_d;
  logic            tick, fstart, fwd;
  logic [BW-1:0]   fb;
  logic [CH_W-1:0] fc;

  assign tick   = (state != IDLE) && (div_cnt == DIV_MAX);
  assign fstart = (bit_cnt == '0) && (ch == '0);
  assign o_busy = (state != IDLE);

  // Next state, counters and next registered outputs.
  always_comb begin
    state_d = state;
    div_d   = div_cnt;
    bit_d   = bit_cnt;
    ch_d    = ch;
    en_d    = 1'b0;
    din_d   = o_des_din;
    vld_d   = 1'b0;
    och_d   = ov_ch;
    err_d   = 1'b0;
    fwd     = 1'b0;
    fb      = bit_cnt;
    fc      = ch;
    if (state != IDLE)
      div_d = tick ? '0 : div_cnt + 1'b1;
    if (!i_start) begin
      state_d = IDLE;
      div_d   = '0;
      bit_d   = '0;
      ch_d    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_d = WAIT_SYNC;
          div_d   = '0;
        end
        WAIT_SYNC: begin
          if (tick && i_fsync) begin
            fwd     = 1'b1;
            fb      = '0;
            fc      = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (tick) begin
            unique case (1'b1)
              (fstart && !i_fsync): begin
                err_d   = 1'b1;
                state_d = WAIT_SYNC;
                div_d   = '0;
              end
              (!fstart && i_fsync): begin
                err_d = 1'b1;
                fwd   = 1'b1;
                fb    = '0;
                fc    = '0;
              end
              default: fwd = 1'b1;
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
      if (fwd) begin
        en_d  = 1'b1;
        din_d = i_sdata;
        och_d = fc;
        if (fb == BIT_MAX) begin
          vld_d = 1'b1;
          bit_d = '0;
          ch_d  = (fc == CH_MAX) ? '0 : fc + 1'b1;
        end else begin
          bit_d = fb + 1'b1;
          ch_d  = fc;
        end
      end
    end
  end

  // State, counters and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      div_cnt         <= '0;
      bit_cnt         <= '0;
      ch              <= '0;
      o_des_en        <= 1'b0;
      o_des_din       <= 1'b0;
      o_des_din_valid <= 1'b0;
      ov_ch           <= '0;
      o_sync_err      <= 1'b0;
    end else begin
      state           <= state_d;
      div_cnt         <= div_d;
      bit_cnt         <= bit_d;
      ch              <= ch_d;
      o_des_en        <= en_d;
      o_des_din       <= din_d;
      o_des_din_valid <= vld_d;
      ov_ch           <= och_d;
      o_sync_err      <= err_d;
    end
  end

`ifdef SYNC_ERR_CNT_EN
  // Saturating count of sync-error pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      ov_err_cnt <= '0;
    else if (err_d && (ov_err_cnt != 8'hFF))
      ov_err_cnt <= ov_err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_tdm_deser_ctrl.sv
// Directed bench for tdm_deser_ctrl with a simple LSB-first deserializer model.
// Define SYNC_ERR_CNT_EN to also exercise the error counter.
module tb_tdm_deser_ctrl;

  logic i_clk, i_rst, i_start, i_fsync, i_sdata;
  logic o_des_en, o_des_din, o_des_din_valid;
  logic [0:0] ov_ch;
  logic o_busy, o_sync_err;
`ifdef SYNC_ERR_CNT_EN
  logic [7:0] ov_err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int en_cnt = 0;
  logic mid_en;
  logic [23:0] sr;
  logic [23:0] des_word;

  tdm_deser_ctrl #(
    .WORD_LEN(24),
    .NUM_CH(2),
    .CH_W(1),
    .BCLK_DIV(4)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_fsync(i_fsync),
    .i_sdata(i_sdata),
    .o_des_en(o_des_en),
    .o_des_din(o_des_din),
    .o_des_din_valid(o_des_din_valid),
    .ov_ch(ov_ch),
    .o_busy(o_busy),
    .o_sync_err(o_sync_err)
`ifdef SYNC_ERR_CNT_EN
    ,
    .ov_err_cnt(ov_err_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Downstream deserializer: shift right, newest bit enters at the MSB.
  always @(posedge i_clk)
    if (o_des_en) sr <= {o_des_din, sr[23:1]};
  assign des_word = {o_des_din, sr[23:1]};

  always @(posedge o_des_en) en_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit period; returns #1 after the tick edge.
  task automatic tick_in(input logic fs, input logic sd);
    i_fsync = fs;
    i_sdata = sd;
    @(posedge i_clk);
    #1 mid_en = o_des_en;
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic send_word(input logic [23:0] w, input logic fs0,
                           input int chx, input int nb,
                           input logic e0, input int npulse);
    for (int i = 0; i < nb; i++) begin
      tick_in((i == 0) ? fs0 : 1'b0, w[i]);
      chk("bit",
          32'({mid_en, o_des_en, o_des_din_valid, o_des_din, o_sync_err}),
          32'({1'b0, 1'b1, (i == 23), w[i], (i == 0) && e0}));
      if (i == 23) begin
        chk("ch", 32'(ov_ch), 32'(chx));
        chk("word", 32'(des_word), 32'(w));
        chk("npulse", 32'(en_cnt), 32'(npulse));
      end
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_start = 1'b0;
    i_fsync = 1'b0;
    i_sdata = 1'b0;
    mid_en = 1'b0;
    #1;
    chk("rst_out", 32'({o_des_en, o_des_din, o_des_din_valid, ov_ch,
                        o_busy, o_sync_err}), 32'd0);
    #20;
    @(negedge i_clk) i_rst = 1'b0;
    @(posedge i_clk);
    #1 chk("idle_busy", 32'(o_busy), 32'd0);

    // Start, two dropped ticks, fsync on the third, two frames.
    i_start = 1'b1;
    @(posedge i_clk);
    #1 chk("start_busy", 32'(o_busy), 32'd1);
    tick_in(1'b0, 1'b1);
    chk("ws_drop1", 32'({o_des_en, o_sync_err}), 32'd0);
    tick_in(1'b0, 1'b0);
    chk("ws_drop2", 32'({o_des_en, o_sync_err}), 32'd0);
    send_word(24'hA5C3F0, 1'b1, 0, 24, 1'b0, 24);
    send_word(24'h00FF01, 1'b0, 1, 24, 1'b0, 48);
    send_word(24'hA5C3F0, 1'b1, 0, 24, 1'b0, 72);
    send_word(24'h00FF01, 1'b0, 1, 24, 1'b0, 96);

    // Misplaced fsync at bit 10 of ch1.
    send_word(24'h3C3C3C, 1'b1, 0, 24, 1'b0, 120);
    send_word(24'h00FF01, 1'b0, 1, 10, 1'b0, 0);
    send_word(24'h123456, 1'b1, 0, 24, 1'b1, 154);
    send_word(24'h5A5A5A, 1'b0, 1, 24, 1'b0, 178);

    // Missing fsync at frame start.
    tick_in(1'b0, 1'b1);
    chk("miss_err", 32'({o_sync_err, o_des_en, o_busy}), 32'b101);
    tick_in(1'b0, 1'b0);
    chk("miss_wait", 32'({o_sync_err, o_des_en, o_busy}), 32'b001);
    send_word(24'hA5C3F0, 1'b1, 0, 24, 1'b0, 202);

    // Stop before bit 12 of ch1.
    send_word(24'hFFFFFF, 1'b0, 1, 12, 1'b0, 0);
    i_start = 1'b0;
    @(posedge i_clk);
    #1 chk("stop_busy", 32'({o_busy, o_des_en}), 32'd0);
    repeat (8) @(posedge i_clk);
    #1 chk("stop_quiet", 32'(en_cnt), 32'd214);

    // Restart, then asynchronous reset mid-word in ch1.
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    send_word(24'hA5C3F0, 1'b1, 0, 24, 1'b0, 238);
    send_word(24'h0000FF, 1'b0, 1, 5, 1'b0, 0);
    chk("pre_rst", 32'({o_des_en, o_des_din, ov_ch, o_busy}), 32'hF);
    #2 i_rst = 1'b1;
    #1;
    chk("async_rst", 32'({o_des_en, o_des_din, o_des_din_valid, ov_ch,
                          o_busy, o_sync_err}), 32'd0);
    i_start = 1'b0;
    #20;
    @(negedge i_clk) i_rst = 1'b0;
    @(posedge i_clk);
    #1 chk("post_rst", 32'({o_busy, o_des_en}), 32'd0);

`ifdef SYNC_ERR_CNT_EN
    chk("cnt_rst", 32'(ov_err_cnt), 32'd0);
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    tick_in(1'b1, 1'b0);
    chk("cnt_first", 32'(ov_err_cnt), 32'd0);
    repeat (254) tick_in(1'b1, 1'b0);
    chk("cnt_254", 32'(ov_err_cnt), 32'd254);
    repeat (46) tick_in(1'b1, 1'b0);
    chk("cnt_sat", 32'(ov_err_cnt), 32'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
